// File: rtl/regn_mode_fsm_pkg.sv
// Shared mode encoding for the mode-controlled timer register.
// Mode codes double as the state register encoding.
package regn_mode_fsm_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    LD  = 3'd0,
    INC = 3'd1,
    DEC = 3'd2,
    SHL = 3'd3,
    SHR = 3'd4
  } mode_e;

  function automatic logic mode_legal(
    input logic [MODE_W-1:0] m
  );
    return (m <= SHR);
  endfunction

endpackage

// File: rtl/regn_mode_fsm_if.sv
// Control/data bundle between a timer block and its mode register.
// master drives requests and data, slave returns contents and tc.
interface regn_mode_fsm_if #(
  parameter int WIDTH = 8
);
  import regn_mode_fsm_pkg::*;

  logic [MODE_W-1:0] mode;
  logic              en;
  logic              clr;
  logic              sin;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic [MODE_W-1:0] state;
  logic              tc;

  modport master (
    output mode,
    output en,
    output clr,
    output sin,
    output in,
    input  out,
    input  state,
    input  tc
  );

  modport slave (
    input  mode,
    input  en,
    input  clr,
    input  sin,
    input  in,
    output out,
    output state,
    output tc
  );

endinterface

// File: rtl/regn_mode_fsm_addsub.sv
// Shared step adder/subtractor for INC and DEC.
// flag is carry on add and borrow on subtract.
module regn_mode_fsm_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  // Step is truncated to the datapath width, unsigned only.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] sum;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, STEP_W};

  always_comb begin
    sum = '0;
    if (sub) begin
      sum = a_x - b_x;
    end else begin
      sum = a_x + b_x;
    end
  end

  assign result = sum[WIDTH-1:0];
  assign flag   = sum[WIDTH];

endmodule

// File: rtl/regn_mode_fsm.sv
// Mode-controlled general register: load, inc, dec, shifts,
// wrap/saturate policy and a registered terminal-count pulse.
module regn_mode_fsm
  import regn_mode_fsm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HIGH     = WIDTH - 1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input logic            clk,
  input logic            rst_n,
  regn_mode_fsm_if.slave bus
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic             SAT  = (SATURATE != 0);

  mode_e            state_q;
  mode_e            state_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             tc_q;
  logic             tc_d;

  logic             as_sub;
  logic [WIDTH-1:0] as_res;
  logic             as_flag;

  regn_mode_fsm_addsub #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_addsub (
    .a      (out_q),
    .sub    (as_sub),
    .result (as_res),
    .flag   (as_flag)
  );

  assign as_sub = (state_q == DEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD;
      out_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
    end
  end

  // Mode tracks the request every cycle, independent of en/clr.
  always_comb begin
    state_d = state_q;
    if (mode_legal(bus.mode)) begin
      state_d = mode_e'(bus.mode);
    end
  end

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (bus.clr) begin
      out_d = '0;
    end else if (bus.en) begin
      unique case (1'b1)
        (state_q == LD): begin
          out_d = bus.in;
        end
        (state_q == INC): begin
          out_d = as_res;
          tc_d  = as_flag;
          if (as_flag && SAT) begin
            out_d = ONES;
          end
        end
        (state_q == DEC): begin
          out_d = as_res;
          tc_d  = as_flag;
          if (as_flag && SAT) begin
            out_d = ZERO;
          end
        end
        (state_q == SHL): begin
          out_d = {out_q[HIGH-1:0], bus.sin};
        end
        (state_q == SHR): begin
          out_d = {bus.sin, out_q[HIGH:1]};
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.state = state_q;
  assign bus.tc    = tc_q;

endmodule
